// File: rtl/rob.sv
// Reorder buffer for an R10000-style out-of-order core.
// Each dispatched instruction takes one circular-buffer entry holding its new tag T,
// its previous mapping Told and the free-list tail pointer at dispatch. Entries retire
// in program order, which hands Told back to the free list. A branch mispredict squashes
// every entry younger than the branch and exposes the free-list rollback pointer.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-low reset
//   dispatch_*                   allocation request and the fields stored in the new entry
//   complete_en/_ROB_idx         CDB broadcast marking an entry complete
//   rollback_en/_ROB_idx         mispredicted branch; younger entries are squashed
//   ROB_valid, ROB_idx           space available / entry the current dispatch occupies
//   retire_en, retire_*          head entry retires at the next edge; its fields
//   FL_rollback_idx              stored free-list pointer of entry rollback_ROB_idx
//   halted                       a HALT instruction has retired
module rob #(
   parameter int unsigned NUM_ROB = 16,
   parameter int unsigned NUM_PR  = 64,
   parameter int unsigned NUM_FL  = 32,
   parameter int unsigned ZERO_PR = 31,
   localparam int unsigned RI = $clog2(NUM_ROB),
   localparam int unsigned PW = $clog2(NUM_PR),
   localparam int unsigned FW = $clog2(NUM_FL)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          dispatch_en,
   input  logic [4:0]    dispatch_dest_idx,
   input  logic [PW-1:0] dispatch_T_idx,
   input  logic [PW-1:0] dispatch_Told_idx,
   input  logic [FW-1:0] dispatch_FL_idx,
   input  logic          dispatch_halt,
   input  logic          complete_en,
   input  logic [RI-1:0] complete_ROB_idx,
   input  logic          rollback_en,
   input  logic [RI-1:0] rollback_ROB_idx,
   output logic          ROB_valid,
   output logic [RI-1:0] ROB_idx,
   output logic          retire_en,
   output logic [4:0]    retire_dest_idx,
   output logic [PW-1:0] retire_T_idx,
   output logic [PW-1:0] retire_Told_idx,
   output logic [FW-1:0] FL_rollback_idx,
   output logic          halted
);

   localparam logic [RI:0] FullCount = (RI+1)'(NUM_ROB);

   typedef enum logic {StRun, StHalted} mode_e;

   mode_e              mode_q, mode_d;
   logic [RI-1:0]      head_q, head_d, tail_q, tail_d;
   logic [RI:0]        count_q, count_d;
   logic [NUM_ROB-1:0] valid_q, valid_d, complete_q, complete_d, halt_q;
   logic [4:0]         dest_q [NUM_ROB];
   logic [PW-1:0]      t_q    [NUM_ROB];
   logic [PW-1:0]      told_q [NUM_ROB];
   logic [FW-1:0]      fl_q   [NUM_ROB];

   logic               do_dispatch;
   logic [RI-1:0]      rel_b, rel_i;
   logic [NUM_ROB-1:0] squash;

   assign ROB_valid       = (count_q != FullCount);
   assign ROB_idx         = tail_q;
   assign halted          = (mode_q == StHalted);
   assign FL_rollback_idx = fl_q[rollback_ROB_idx];
   assign do_dispatch     = dispatch_en && ROB_valid && !rollback_en && (mode_q == StRun);
   assign retire_en       = (mode_q == StRun) && !rollback_en && valid_q[head_q] &&
                            complete_q[head_q];

   always_comb begin
      retire_dest_idx = '0;
      retire_T_idx    = '0;
      retire_Told_idx = '0;
      if (valid_q[head_q]) begin
         retire_dest_idx = dest_q[head_q];
         retire_T_idx    = t_q[head_q];
         retire_Told_idx = told_q[head_q];
      end
   end

   // Age is measured as distance from head, so an entry is younger than the branch
   // exactly when its distance exceeds the branch's; this handles wrap-around for free.
   always_comb begin
      squash = '0;
      rel_i  = '0;
      rel_b  = rollback_ROB_idx - head_q;
      for (int i = 0; i < NUM_ROB; i++) begin
         rel_i     = RI'(i) - head_q;
         squash[i] = rollback_en && (rel_i > rel_b);
      end
   end

   always_comb begin
      valid_d    = valid_q;
      complete_d = complete_q;
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      mode_d     = mode_q;
      if (complete_en && valid_q[complete_ROB_idx] && !squash[complete_ROB_idx]) begin
         complete_d[complete_ROB_idx] = 1'b1;
      end
      if (rollback_en) begin
         valid_d    = valid_q & ~squash;
         complete_d = complete_d & ~squash;
         tail_d     = rollback_ROB_idx + 1'b1;
         count_d    = {1'b0, rel_b} + 1'b1;
      end else begin
         if (retire_en) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
            if (halt_q[head_q]) begin
               mode_d = StHalted;
            end
         end
         if (do_dispatch) begin
            valid_d[tail_q]    = 1'b1;
            complete_d[tail_q] = 1'b0;
            tail_d             = tail_q + 1'b1;
         end
         count_d = count_q + (RI+1)'(do_dispatch) - (RI+1)'(retire_en);
      end
   end

   // The zero register is never renamed, so the free list must never hand out its tag.
   always_comb begin
      if (reset && do_dispatch) begin
         zero_tag_not_allocated: assert (dispatch_T_idx != PW'(ZERO_PR));
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mode_q     <= StRun;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         valid_q    <= '0;
         complete_q <= '0;
         halt_q     <= '0;
         for (int i = 0; i < NUM_ROB; i++) begin
            dest_q[i] <= '0;
            t_q[i]    <= '0;
            told_q[i] <= '0;
            fl_q[i]   <= '0;
         end
      end else begin
         mode_q     <= mode_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         complete_q <= complete_d;
         if (do_dispatch) begin
            dest_q[tail_q] <= dispatch_dest_idx;
            t_q[tail_q]    <= dispatch_T_idx;
            told_q[tail_q] <= dispatch_Told_idx;
            fl_q[tail_q]   <= dispatch_FL_idx;
            halt_q[tail_q] <= dispatch_halt;
         end
      end
   end

endmodule

// File: tb/tb_rob.sv
// Directed testbench for rob: dispatch, completion, in-order retire, full condition,
// rollback with wrap-around, rollback collisions, HALT and asynchronous reset.
module tb_rob;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       dispatch_en;
   logic [4:0] dispatch_dest_idx;
   logic [5:0] dispatch_T_idx;
   logic [5:0] dispatch_Told_idx;
   logic [4:0] dispatch_FL_idx;
   logic       dispatch_halt;
   logic       complete_en;
   logic [3:0] complete_ROB_idx;
   logic       rollback_en;
   logic [3:0] rollback_ROB_idx;
   logic       ROB_valid;
   logic [3:0] ROB_idx;
   logic       retire_en;
   logic [4:0] retire_dest_idx;
   logic [5:0] retire_T_idx;
   logic [5:0] retire_Told_idx;
   logic [4:0] FL_rollback_idx;
   logic       halted;

   int n_cmp = 0;
   int n_bad = 0;

   rob #(.NUM_ROB(16), .NUM_PR(64), .NUM_FL(32), .ZERO_PR(31)) dut (
      .clock             (clock),
      .reset             (reset),
      .dispatch_en       (dispatch_en),
      .dispatch_dest_idx (dispatch_dest_idx),
      .dispatch_T_idx    (dispatch_T_idx),
      .dispatch_Told_idx (dispatch_Told_idx),
      .dispatch_FL_idx   (dispatch_FL_idx),
      .dispatch_halt     (dispatch_halt),
      .complete_en       (complete_en),
      .complete_ROB_idx  (complete_ROB_idx),
      .rollback_en       (rollback_en),
      .rollback_ROB_idx  (rollback_ROB_idx),
      .ROB_valid         (ROB_valid),
      .ROB_idx           (ROB_idx),
      .retire_en         (retire_en),
      .retire_dest_idx   (retire_dest_idx),
      .retire_T_idx      (retire_T_idx),
      .retire_Told_idx   (retire_Told_idx),
      .FL_rollback_idx   (FL_rollback_idx),
      .halted            (halted)
   );

   always #5 clock = ~clock;

   task automatic clear_inputs();
      dispatch_en       = 1'b0;
      dispatch_dest_idx = '0;
      dispatch_T_idx    = '0;
      dispatch_Told_idx = '0;
      dispatch_FL_idx   = '0;
      dispatch_halt     = 1'b0;
      complete_en       = 1'b0;
      complete_ROB_idx  = '0;
      rollback_en       = 1'b0;
      rollback_ROB_idx  = '0;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive_dispatch(input logic [4:0] dest, input logic [5:0] t,
                                 input logic [5:0] told, input logic [4:0] fl,
                                 input logic hlt);
      clear_inputs();
      dispatch_en       = 1'b1;
      dispatch_dest_idx = dest;
      dispatch_T_idx    = t;
      dispatch_Told_idx = told;
      dispatch_FL_idx   = fl;
      dispatch_halt     = hlt;
   endtask

   task automatic drive_complete(input logic [3:0] idx);
      clear_inputs();
      complete_en      = 1'b1;
      complete_ROB_idx = idx;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      #2;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      #2;
      n_cmp++; if (ROB_valid !== 1'b1) begin n_bad++; $display("FAIL reset_rob_valid got %0d want 1", ROB_valid); end
      n_cmp++; if (ROB_idx !== 4'd0) begin n_bad++; $display("FAIL reset_rob_idx got %0d want 0", ROB_idx); end
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL reset_retire_en got %0d want 0", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd0) begin n_bad++; $display("FAIL reset_retire_told got %0d want 0", retire_Told_idx); end
      n_cmp++; if (FL_rollback_idx !== 5'd0) begin n_bad++; $display("FAIL reset_fl_rollback got %0d want 0", FL_rollback_idx); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %0d want 0", halted); end
      #1;
      reset = 1'b1;
      tick();
   endtask

   task automatic test_dispatch();
      for (int i = 0; i < 3; i++) begin
         drive_dispatch(5'(i + 1), 6'(32 + i), 6'(1 + i), 5'(i + 1), 1'b0);
         #2;
         n_cmp++; if (ROB_idx !== 4'(i)) begin n_bad++; $display("FAIL dispatch_rob_idx[%0d] got %0d want %0d", i, ROB_idx, i); end
         tick();
      end
      clear_inputs();
      #2;
      n_cmp++; if (ROB_idx !== 4'd3) begin n_bad++; $display("FAIL dispatch_tail got %0d want 3", ROB_idx); end
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL dispatch_no_retire got %0d want 0", retire_en); end
      n_cmp++; if (retire_T_idx !== 6'd32) begin n_bad++; $display("FAIL dispatch_head_T got %0d want 32", retire_T_idx); end
      tick();
   endtask

   task automatic test_complete_retire();
      drive_complete(4'd1);
      #2;
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL cr_young_complete got %0d want 0", retire_en); end
      tick();
      drive_complete(4'd0);
      #2;
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL cr_same_cycle got %0d want 0", retire_en); end
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (retire_en !== 1'b1) begin n_bad++; $display("FAIL cr_retire0_en got %0d want 1", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd1) begin n_bad++; $display("FAIL cr_retire0_told got %0d want 1", retire_Told_idx); end
      n_cmp++; if (retire_dest_idx !== 5'd1) begin n_bad++; $display("FAIL cr_retire0_dest got %0d want 1", retire_dest_idx); end
      tick();
      #2;
      n_cmp++; if (retire_en !== 1'b1) begin n_bad++; $display("FAIL cr_retire1_en got %0d want 1", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd2) begin n_bad++; $display("FAIL cr_retire1_told got %0d want 2", retire_Told_idx); end
      tick();
      #2;
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL cr_head2_stall got %0d want 0", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd3) begin n_bad++; $display("FAIL cr_head2_told got %0d want 3", retire_Told_idx); end
      tick();
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drive_dispatch(5'(i), 6'(32 + i), 6'(i), 5'(i), 1'b0);
         #2;
         n_cmp++; if (ROB_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid_before[%0d] got %0d want 1", i, ROB_valid); end
         tick();
      end
      drive_dispatch(5'd9, 6'd63, 6'd9, 5'd9, 1'b0);
      #2;
      n_cmp++; if (ROB_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_after got %0d want 0", ROB_valid); end
      tick();
      drive_complete(4'd0);
      #2;
      n_cmp++; if (ROB_idx !== 4'd0) begin n_bad++; $display("FAIL full_17th_tail got %0d want 0", ROB_idx); end
      n_cmp++; if (dut.count_q !== 5'd16) begin n_bad++; $display("FAIL full_17th_count got %0d want 16", dut.count_q); end
      tick();
      drive_dispatch(5'd9, 6'd62, 6'd9, 5'd9, 1'b0);
      #2;
      n_cmp++; if (retire_en !== 1'b1) begin n_bad++; $display("FAIL full_retire_en got %0d want 1", retire_en); end
      n_cmp++; if (ROB_valid !== 1'b0) begin n_bad++; $display("FAIL full_no_bypass got %0d want 0", ROB_valid); end
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (ROB_valid !== 1'b1) begin n_bad++; $display("FAIL full_freed got %0d want 1", ROB_valid); end
      n_cmp++; if (ROB_idx !== 4'd0) begin n_bad++; $display("FAIL full_blocked_tail got %0d want 0", ROB_idx); end
      n_cmp++; if (dut.count_q !== 5'd15) begin n_bad++; $display("FAIL full_count got %0d want 15", dut.count_q); end
      tick();
   endtask

   task automatic test_rollback_wrap();
      do_reset();
      for (int i = 0; i < 14; i++) begin
         drive_dispatch(5'(i), 6'(32 + i), 6'(i), 5'(i), 1'b0);
         tick();
      end
      for (int i = 0; i < 14; i++) begin
         drive_complete(4'(i));
         tick();
      end
      clear_inputs();
      tick();
      #2;
      n_cmp++; if (dut.count_q !== 5'd0) begin n_bad++; $display("FAIL rbw_drained_count got %0d want 0", dut.count_q); end
      n_cmp++; if (ROB_idx !== 4'd14) begin n_bad++; $display("FAIL rbw_drained_tail got %0d want 14", ROB_idx); end
      for (int k = 0; k < 6; k++) begin
         drive_dispatch(5'(k + 1), 6'(40 + k), 6'(10 + k), 5'(5 + 2 * k), 1'b0);
         tick();
      end
      clear_inputs();
      #2;
      n_cmp++; if (ROB_idx !== 4'd4) begin n_bad++; $display("FAIL rbw_wrapped_tail got %0d want 4", ROB_idx); end
      n_cmp++; if (dut.count_q !== 5'd6) begin n_bad++; $display("FAIL rbw_count6 got %0d want 6", dut.count_q); end
      rollback_en      = 1'b1;
      rollback_ROB_idx = 4'd0;
      #2;
      n_cmp++; if (FL_rollback_idx !== 5'd9) begin n_bad++; $display("FAIL rbw_fl_rollback got %0d want 9", FL_rollback_idx); end
      tick();
      drive_complete(4'd2);
      #2;
      n_cmp++; if (ROB_idx !== 4'd1) begin n_bad++; $display("FAIL rbw_tail got %0d want 1", ROB_idx); end
      n_cmp++; if (dut.count_q !== 5'd3) begin n_bad++; $display("FAIL rbw_count got %0d want 3", dut.count_q); end
      n_cmp++; if (dut.valid_q[3:1] !== 3'b000) begin n_bad++; $display("FAIL rbw_squashed got %b want 000", dut.valid_q[3:1]); end
      n_cmp++; if (dut.valid_q[0] !== 1'b1) begin n_bad++; $display("FAIL rbw_branch_valid got %0d want 1", dut.valid_q[0]); end
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (dut.complete_q[2] !== 1'b0) begin n_bad++; $display("FAIL rbw_late_complete got %0d want 0", dut.complete_q[2]); end
   endtask

   task automatic test_rollback_collide();
      // head = 14, tail = 1, count = 3 from the previous scenario
      drive_complete(4'd14);
      tick();
      drive_dispatch(5'd7, 6'd60, 6'd7, 5'd7, 1'b0);
      rollback_en      = 1'b1;
      rollback_ROB_idx = 4'd15;
      #2;
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL rbc_retire_suppressed got %0d want 0", retire_en); end
      n_cmp++; if (FL_rollback_idx !== 5'd7) begin n_bad++; $display("FAIL rbc_fl_rollback got %0d want 7", FL_rollback_idx); end
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (dut.count_q !== 5'd2) begin n_bad++; $display("FAIL rbc_count got %0d want 2", dut.count_q); end
      n_cmp++; if (ROB_idx !== 4'd0) begin n_bad++; $display("FAIL rbc_tail got %0d want 0", ROB_idx); end
      n_cmp++; if (retire_en !== 1'b1) begin n_bad++; $display("FAIL rbc_retire_after got %0d want 1", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd10) begin n_bad++; $display("FAIL rbc_head_told got %0d want 10", retire_Told_idx); end
      tick();
   endtask

   task automatic test_halt();
      do_reset();
      drive_dispatch(5'd1, 6'd50, 6'd1, 5'd1, 1'b0);
      tick();
      drive_dispatch(5'd2, 6'd51, 6'd2, 5'd2, 1'b1);
      tick();
      drive_dispatch(5'd3, 6'd52, 6'd3, 5'd3, 1'b0);
      tick();
      for (int i = 2; i >= 0; i--) begin
         drive_complete(4'(i));
         tick();
      end
      clear_inputs();
      #2;
      n_cmp++; if (retire_Told_idx !== 6'd1) begin n_bad++; $display("FAIL halt_first_told got %0d want 1", retire_Told_idx); end
      tick();
      #2;
      n_cmp++; if (retire_en !== 1'b1) begin n_bad++; $display("FAIL halt_retire_en got %0d want 1", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd2) begin n_bad++; $display("FAIL halt_told got %0d want 2", retire_Told_idx); end
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL halt_early got %0d want 0", halted); end
      tick();
      drive_dispatch(5'd4, 6'd53, 6'd4, 5'd4, 1'b0);
      #2;
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_set got %0d want 1", halted); end
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL halt_no_retire got %0d want 0", retire_en); end
      n_cmp++; if (retire_Told_idx !== 6'd3) begin n_bad++; $display("FAIL halt_head_told got %0d want 3", retire_Told_idx); end
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (ROB_idx !== 4'd3) begin n_bad++; $display("FAIL halt_dispatch_blocked got %0d want 3", ROB_idx); end
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL halt_sticky got %0d want 0", retire_en); end
   endtask

   task automatic test_reset_mid();
      reset = 1'b0;
      #1;
      n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL rmid_halted got %0d want 0", halted); end
      n_cmp++; if (ROB_idx !== 4'd0) begin n_bad++; $display("FAIL rmid_rob_idx got %0d want 0", ROB_idx); end
      n_cmp++; if (ROB_valid !== 1'b1) begin n_bad++; $display("FAIL rmid_rob_valid got %0d want 1", ROB_valid); end
      n_cmp++; if (retire_Told_idx !== 6'd0) begin n_bad++; $display("FAIL rmid_retire_told got %0d want 0", retire_Told_idx); end
      n_cmp++; if (retire_T_idx !== 6'd0) begin n_bad++; $display("FAIL rmid_retire_T got %0d want 0", retire_T_idx); end
      n_cmp++; if (retire_en !== 1'b0) begin n_bad++; $display("FAIL rmid_retire_en got %0d want 0", retire_en); end
      reset = 1'b1;
      tick();
      drive_dispatch(5'd5, 6'd33, 6'd5, 5'd5, 1'b0);
      tick();
      clear_inputs();
      #2;
      n_cmp++; if (ROB_idx !== 4'd1) begin n_bad++; $display("FAIL rmid_dispatch_resumes got %0d want 1", ROB_idx); end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_dispatch();
      test_complete_retire();
      test_full();
      test_rollback_wrap();
      test_rollback_collide();
      test_halt();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
